rcv_phy_deframer: RTL and testbench
===================================

Name: rcv_phy_deframer

Overview:
- Receive-side counterpart of the transmit PHY path: the transmitter sends frames as a nibble stream qualified by a transmit enable; this block reassembles them.
- Converts the nibble stream into bytes.
- Counts bytes, checks frame length and nibble parity, and emits a per-frame 24-bit control word in the transmit control-word format.
- Sits on the PHY clock domain, directly behind the PHY receive pins, feeding a downstream receive buffer.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes.
- MAX_LEN, 1518, maximum legal frame length in bytes; must be ≤ 4095.

Ports:
- clk_phy  input  1  PHY nibble clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- phy_rx_data  input  4  received nibble, low nibble of each byte first.
- phy_rx_en  input  1  frame qualifier; high for every nibble of a frame.
- r_data_out  output  8  assembled byte, {hi nibble, lo nibble}.
- r_data_valid  output  1  one-cycle strobe per assembled byte.
- r_frame_valid  output  1  one-cycle pulse at end of a good frame.
- r_frame_err  output  1  one-cycle pulse at end of a bad frame.
- r_err_code  output  2  00 none, 01 runt, 10 giant, 11 odd nibble; valid with either end pulse.
- r_ctrl_out  output  24  {len[11:0], len[11:0]}; valid with either end pulse.
- r_good_cnt  output  16  good-frame counter; wraps.
- r_err_cnt  output  16  bad-frame counter; saturates at 0xFFFF.

Behaviour:
- Reset (reset=0, async):
  - All outputs go to 0.
  - Byte counter cleared.
  - State goes to WAIT_IDLE.
- States:
  - WAIT_IDLE: stay until phy_rx_en is sampled 0, then go to IDLE. Prevents locking onto a partial frame after reset is released mid-frame.
  - IDLE: on phy_rx_en=1, capture phy_rx_data as the lo nibble, clear the byte counter, go to HI.
  - HI:
    - phy_rx_en=1: capture the hi nibble. On that same edge, register r_data_out and set r_data_valid for the following cycle, increment len, go to LO.
    - phy_rx_en=0: odd-nibble end, go to END with code 11.
  - LO:
    - phy_rx_en=1: capture the lo nibble, go to HI.
    - phy_rx_en=0: normal end, go to END.
  - END:
    - Lasts one cycle.
    - r_frame_valid or r_frame_err is high in this cycle; they are mutually exclusive.
    - r_ctrl_out and r_err_code are held from this cycle until the next end pulse.
    - Next edge: if phy_rx_en=1, capture the lo nibble, clear len, go to HI (back-to-back frames with a 1-cycle gap are legal). Otherwise go to IDLE.
- Latency:
  - Byte out: 1 cycle after the edge sampling its hi nibble.
  - End pulse: the cycle after the first edge that samples phy_rx_en=0.
- len rules:
  - 12-bit; increments once per complete byte; saturates at 4095.
  - The partial byte of an odd-nibble frame is not counted and never strobed.
- Error priority: odd nibble (11) > runt, len < MIN_LEN (01) > giant, len > MAX_LEN (10).
- Counters:
  - Good frame: r_good_cnt +1, wrapping 0xFFFF→0.
  - Bad frame: r_err_cnt +1, holding at 0xFFFF.
  - Both updated on the edge entering END, so the new value is visible in the END cycle.
- r_data_valid: asserted only in the cycle after a HI→LO transition; never in IDLE, WAIT_IDLE or END.
- Reset mid-frame: no end pulse and no counter update for the aborted frame; the block resyncs via WAIT_IDLE.
- phy_rx_data is don't-care whenever phy_rx_en=0.

Test Plan:
- 64-byte frame (bytes 00×4, FF×56, 00×4; 128 nibbles, lo first) -> 64 r_data_valid strobes with data 00,00,00,00,FF…,00; r_frame_valid pulse; r_ctrl_out=0x040040; r_err_code=00; r_good_cnt=1.
- 10-byte frame -> r_frame_err pulse; r_err_code=01; r_ctrl_out=0x00A00A; r_err_cnt=1; r_good_cnt unchanged.
- 129-nibble frame -> 64 bytes strobed; r_frame_err pulse; r_err_code=11; r_ctrl_out=0x040040.
- 1519-byte frame with MAX_LEN=1518 -> r_err_code=10; r_ctrl_out=0x5EF5EF.
- Two 64-byte frames separated by exactly one phy_rx_en=0 cycle -> two r_frame_valid pulses, 128 byte strobes total, r_good_cnt=2.
- Reset asserted at nibble 50 and released while phy_rx_en is still 1 -> all outputs 0 during reset; no bytes and no end pulse for the remainder of that frame; the next frame after phy_rx_en drops is received normally (r_good_cnt=1).

Source files
------------

// File: rtl/rcv_phy_deframer.sv
// Receive PHY deframer: reassembles a lo-nibble-first stream into bytes and
// reports per-frame length/status as a {len, len} control word plus counters.
module rcv_phy_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk_phy,
  input  logic        reset,
  input  logic [3:0]  phy_rx_data,
  input  logic        phy_rx_en,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic        r_frame_valid,
  output logic        r_frame_err,
  output logic [1:0]  r_err_code,
  output logic [23:0] r_ctrl_out,
  output logic [15:0] r_good_cnt,
  output logic [15:0] r_err_cnt
);

  localparam logic [11:0] MIN_L   = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L   = 12'(MAX_LEN);
  localparam logic [11:0] LEN_SAT = 12'hFFF;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_RUNT  = 2'b01;
  localparam logic [1:0] CODE_GIANT = 2'b10;
  localparam logic [1:0] CODE_ODD   = 2'b11;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    HI,
    LO,
    END
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  lo_nib_reg, lo_nib_next;
  logic [11:0] len_reg, len_next;
  logic [7:0]  data_out_reg, data_out_next;
  logic        data_valid_reg, data_valid_next;
  logic        frame_valid_reg, frame_valid_next;
  logic        frame_err_reg, frame_err_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic [23:0] ctrl_reg, ctrl_next;
  logic [15:0] good_cnt_reg, good_cnt_next;
  logic [15:0] err_cnt_reg, err_cnt_next;

  logic        end_now;
  logic        odd_end;
  logic [1:0]  code_c;

  always_comb begin
    state_next       = state_reg;
    lo_nib_next      = lo_nib_reg;
    len_next         = len_reg;
    data_out_next    = data_out_reg;
    data_valid_next  = 1'b0;
    frame_valid_next = 1'b0;
    frame_err_next   = 1'b0;
    err_code_next    = err_code_reg;
    ctrl_next        = ctrl_reg;
    good_cnt_next    = good_cnt_reg;
    err_cnt_next     = err_cnt_reg;
    end_now          = 1'b0;
    odd_end          = 1'b0;
    code_c           = CODE_NONE;

    case (state_reg)
      // Hold off until the line is quiet so a frame already in flight at
      // reset release is ignored rather than half-received.
      WAIT_IDLE: begin
        if (!phy_rx_en) begin
          state_next = IDLE;
        end
      end

      IDLE, END: begin
        if (phy_rx_en) begin
          lo_nib_next = phy_rx_data;
          len_next    = 12'd0;
          state_next  = HI;
        end else begin
          state_next = IDLE;
        end
      end

      HI: begin
        if (phy_rx_en) begin
          data_out_next   = {phy_rx_data, lo_nib_reg};
          data_valid_next = 1'b1;
          if (len_reg != LEN_SAT) begin
            len_next = len_reg + 12'd1;
          end
          state_next = LO;
        end else begin
          end_now    = 1'b1;
          odd_end    = 1'b1;
          state_next = END;
        end
      end

      LO: begin
        if (phy_rx_en) begin
          lo_nib_next = phy_rx_data;
          state_next  = HI;
        end else begin
          end_now    = 1'b1;
          state_next = END;
        end
      end

      default: begin
        state_next = WAIT_IDLE;
      end
    endcase

    // Frame status is resolved on the edge entering END so the pulse, code,
    // control word and updated counter all appear together in the END cycle.
    if (end_now) begin
      if (odd_end) begin
        code_c = CODE_ODD;
      end else if (len_reg < MIN_L) begin
        code_c = CODE_RUNT;
      end else if (len_reg > MAX_L) begin
        code_c = CODE_GIANT;
      end else begin
        code_c = CODE_NONE;
      end

      err_code_next = code_c;
      ctrl_next     = {len_reg, len_reg};

      if (code_c == CODE_NONE) begin
        frame_valid_next = 1'b1;
        good_cnt_next    = good_cnt_reg + 16'd1;
      end else begin
        frame_err_next = 1'b1;
        if (err_cnt_reg != 16'hFFFF) begin
          err_cnt_next = err_cnt_reg + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      state_reg       <= WAIT_IDLE;
      lo_nib_reg      <= 4'd0;
      len_reg         <= 12'd0;
      data_out_reg    <= 8'd0;
      data_valid_reg  <= 1'b0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      err_code_reg    <= 2'd0;
      ctrl_reg        <= 24'd0;
      good_cnt_reg    <= 16'd0;
      err_cnt_reg     <= 16'd0;
    end else begin
      state_reg       <= state_next;
      lo_nib_reg      <= lo_nib_next;
      len_reg         <= len_next;
      data_out_reg    <= data_out_next;
      data_valid_reg  <= data_valid_next;
      frame_valid_reg <= frame_valid_next;
      frame_err_reg   <= frame_err_next;
      err_code_reg    <= err_code_next;
      ctrl_reg        <= ctrl_next;
      good_cnt_reg    <= good_cnt_next;
      err_cnt_reg     <= err_cnt_next;
    end
  end

  assign r_data_out    = data_out_reg;
  assign r_data_valid  = data_valid_reg;
  assign r_frame_valid = frame_valid_reg;
  assign r_frame_err   = frame_err_reg;
  assign r_err_code    = err_code_reg;
  assign r_ctrl_out    = ctrl_reg;
  assign r_good_cnt    = good_cnt_reg;
  assign r_err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_rcv_phy_deframer.sv
// Directed bench for rcv_phy_deframer: frame lengths at and beyond the limits,
// odd-nibble frames, back-to-back frames and reset in the middle of a frame.
module tb_rcv_phy_deframer;

  logic        clk_phy = 1'b0;
  logic        reset;
  logic [3:0]  phy_rx_data;
  logic        phy_rx_en;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_frame_valid;
  logic        r_frame_err;
  logic [1:0]  r_err_code;
  logic [23:0] r_ctrl_out;
  logic [15:0] r_good_cnt;
  logic [15:0] r_err_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Monitor state, written only by the monitor process
  logic [7:0]  byte_q[$];
  int          nvp   = 0;
  int          nep   = 0;
  int          nboth = 0;
  logic [1:0]  last_code;
  logic [23:0] last_ctrl;
  logic [15:0] last_good;
  logic [15:0] last_err;

  // Snapshots taken by the main process before each frame
  int q0, v0, e0;

  rcv_phy_deframer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk_phy      (clk_phy),
    .reset        (reset),
    .phy_rx_data  (phy_rx_data),
    .phy_rx_en    (phy_rx_en),
    .r_data_out   (r_data_out),
    .r_data_valid (r_data_valid),
    .r_frame_valid(r_frame_valid),
    .r_frame_err  (r_frame_err),
    .r_err_code   (r_err_code),
    .r_ctrl_out   (r_ctrl_out),
    .r_good_cnt   (r_good_cnt),
    .r_err_cnt    (r_err_cnt)
  );

  always #5 clk_phy = ~clk_phy;

  always @(negedge clk_phy) begin
    if (r_data_valid) byte_q.push_back(r_data_out);
    if (r_frame_valid) nvp++;
    if (r_frame_err) nep++;
    if (r_frame_valid && r_frame_err) nboth++;
    if (r_frame_valid || r_frame_err) begin
      last_code = r_err_code;
      last_ctrl = r_ctrl_out;
      last_good = r_good_cnt;
      last_err  = r_err_cnt;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int i, input int n);
    if (mode == 0) return (i < 4 || i >= n - 4) ? 8'h00 : 8'hFF;
    return 8'(i * 7 + 3);
  endfunction

  // Inputs change 1 time unit after the falling edge, after the monitor has sampled
  task automatic nib(input logic [3:0] d, input logic en);
    @(negedge clk_phy);
    #1;
    phy_rx_data = d;
    phy_rx_en   = en;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) nib(4'hF, 1'b0);
  endtask

  task automatic send_frame(input int mode, input int nbytes, input int extra);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = pat(mode, i, nbytes);
      nib(b[3:0], 1'b1);
      nib(b[7:4], 1'b1);
    end
    if (extra != 0) nib(4'hA, 1'b1);
  endtask

  task automatic snap();
    q0 = byte_q.size();
    v0 = nvp;
    e0 = nep;
  endtask

  task automatic frame_check(input string tag, input int nbytes, input int nvalid, input int nerr,
                             input logic [1:0] code, input logic [23:0] ctrl,
                             input logic [15:0] good, input logic [15:0] errc);
    check_vec({tag, "_bytes"}, byte_q.size() - q0, nbytes);
    check_vec({tag, "_valid_pulses"}, nvp - v0, nvalid);
    check_vec({tag, "_err_pulses"}, nep - e0, nerr);
    check_vec({tag, "_code"}, {30'd0, last_code}, {30'd0, code});
    check_vec({tag, "_ctrl"}, {8'd0, last_ctrl}, {8'd0, ctrl});
    check_vec({tag, "_good_cnt"}, {16'd0, last_good}, {16'd0, good});
    check_vec({tag, "_err_cnt"}, {16'd0, last_err}, {16'd0, errc});
  endtask

  task automatic pulse_reset();
    @(negedge clk_phy);
    #1;
    reset = 1'b0;
    @(negedge clk_phy);
    #1;
    reset = 1'b1;
    idle(2);
  endtask

  initial begin
    logic [7:0] b;
    reset       = 1'b0;
    phy_rx_en   = 1'b0;
    phy_rx_data = 4'h0;
    repeat (3) @(negedge clk_phy);
    #2;
    check_vec("rst_data", {23'd0, r_data_out, r_data_valid}, 32'd0);
    check_vec("rst_pulses", {29'd0, r_frame_valid, r_frame_err, r_err_code == 2'b00}, 32'd1);
    check_vec("rst_ctrl", {8'd0, r_ctrl_out}, 32'd0);
    check_vec("rst_cnts", {r_good_cnt, r_err_cnt}, 32'd0);
    #1;
    reset = 1'b1;
    idle(3);

    // Minimum-length good frame; every byte checked
    snap();
    send_frame(0, 64, 0);
    idle(4);
    frame_check("t1_64B", 64, 1, 0, 2'b00, 24'h040040, 16'd1, 16'd0);
    for (int i = 0; i < 64; i++) begin
      check_vec($sformatf("t1_byte%0d", i), {24'd0, byte_q[q0 + i]}, {24'd0, pat(0, i, 64)});
    end
    check_vec("t1_ctrl_held", {8'd0, r_ctrl_out}, 32'h040040);

    // Runt
    snap();
    send_frame(1, 10, 0);
    idle(4);
    frame_check("t2_runt10", 10, 0, 1, 2'b01, 24'h00A00A, 16'd1, 16'd1);
    check_vec("t2_byte9", {24'd0, byte_q[q0 + 9]}, {24'd0, pat(1, 9, 10)});

    // Odd nibble count: partial byte must not be strobed
    snap();
    send_frame(1, 64, 1);
    idle(4);
    frame_check("t3_odd129", 64, 0, 1, 2'b11, 24'h040040, 16'd1, 16'd2);

    // Single-nibble frame
    snap();
    nib(4'h3, 1'b1);
    idle(4);
    frame_check("t3b_odd1", 0, 0, 1, 2'b11, 24'h000000, 16'd1, 16'd3);

    // One byte short of minimum
    snap();
    send_frame(1, 63, 0);
    idle(4);
    frame_check("t4_runt63", 63, 0, 1, 2'b01, 24'h03F03F, 16'd1, 16'd4);

    // Exactly maximum is good
    snap();
    send_frame(1, 1518, 0);
    idle(4);
    frame_check("t5_max1518", 1518, 1, 0, 2'b00, 24'h5EE5EE, 16'd2, 16'd4);

    // One byte over maximum
    snap();
    send_frame(1, 1519, 0);
    idle(4);
    frame_check("t6_giant1519", 1519, 0, 1, 2'b10, 24'h5EF5EF, 16'd2, 16'd5);

    // Back-to-back frames with a single idle cycle between them
    pulse_reset();
    snap();
    send_frame(0, 64, 0);
    idle(1);
    send_frame(1, 64, 0);
    idle(4);
    frame_check("t7_b2b", 128, 2, 0, 2'b00, 24'h040040, 16'd2, 16'd0);
    check_vec("t7_f2_byte0", {24'd0, byte_q[q0 + 64]}, {24'd0, pat(1, 0, 64)});

    // Reset asserted at nibble 50, released while the frame is still running
    for (int k = 0; k < 128; k++) begin
      b = pat(1, k / 2, 64);
      nib((k % 2 == 0) ? b[3:0] : b[7:4], 1'b1);
      if (k == 50) begin
        reset = 1'b0;
        #1;
        check_vec("t8_rst_data", {23'd0, r_data_out, r_data_valid}, 32'd0);
        check_vec("t8_rst_ctrl", {8'd0, r_ctrl_out}, 32'd0);
        check_vec("t8_rst_cnts", {r_good_cnt, r_err_cnt}, 32'd0);
        check_vec("t8_rst_pulses", {28'd0, r_frame_valid, r_frame_err, r_err_code}, 32'd0);
        snap();
      end
      if (k == 54) reset = 1'b1;
    end
    idle(4);
    check_vec("t8_abort_bytes", byte_q.size() - q0, 0);
    check_vec("t8_abort_pulses", (nvp - v0) + (nep - e0), 0);
    snap();
    send_frame(0, 64, 0);
    idle(4);
    frame_check("t8_resync", 64, 1, 0, 2'b00, 24'h040040, 16'd1, 16'd0);

    check_vec("both_pulses_never", nboth, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
